// File: rtl/pipeline_hazard_ctrl_if.sv
// Handshake bundle between the datapath (master) and pipeline_hazard_ctrl (slave).
// Carries the hazard-detection inputs and the stage enable/flush/forward outputs.
interface pipeline_hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             id_use_rs;
   logic             id_use_rt;
   logic [4:0]       ex_rd;
   logic             ex_regwrite;
   logic             ex_memread;
   logic [4:0]       mem_rd;
   logic [4:0]       wb_rd;
   logic             mem_regwrite;
   logic             wb_regwrite;
   logic [4:0]       ex_rs;
   logic [4:0]       ex_rt;
   logic             branch_taken;
   logic             dmem_req;
   logic             dmem_ready;
   logic             pc_en;
   logic             ifid_en;
   logic             idex_en;
   logic             exmem_en;
   logic             memwb_en;
   logic             ifid_flush;
   logic             idex_flush;
   logic             memwb_flush;
   logic [1:0]       fwd_a;
   logic [1:0]       fwd_b;
   logic [CNT_W-1:0] stall_cnt;
   logic             err;

   modport master (
      output id_rs, id_rt, id_use_rs, id_use_rt, ex_rd, ex_regwrite, ex_memread,
             mem_rd, wb_rd, mem_regwrite, wb_regwrite, ex_rs, ex_rt,
             branch_taken, dmem_req, dmem_ready,
      input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_flush, idex_flush, memwb_flush, fwd_a, fwd_b, stall_cnt, err
   );

   modport slave (
      input  id_rs, id_rt, id_use_rs, id_use_rt, ex_rd, ex_regwrite, ex_memread,
             mem_rd, wb_rd, mem_regwrite, wb_regwrite, ex_rs, ex_rt,
             branch_taken, dmem_req, dmem_ready,
      output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_flush, idex_flush, memwb_flush, fwd_a, fwd_b, stall_cnt, err
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage pipeline sequencer: stage enables/flushes, load-use/RAW stalls, dmem freeze.
// Optional EX forwarding selects when FORWARD_EN is defined.
module pipeline_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 16
) (
   input logic                  clk,
   input logic                  rst,
   pipeline_hazard_ctrl_if.slave bus
);
   localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERR      = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [CNT_W-1:0]  stall_q, stall_d;
   logic              br_pend_q, br_pend_d;
   logic              hazard_s;
   logic              branch_s;
   logic              pc_en_s, ifid_en_s, idex_en_s, exmem_en_s, memwb_en_s;
   logic              ifid_flush_s, idex_flush_s, memwb_flush_s;
   logic [1:0]        fwd_a_s, fwd_b_s;

   function automatic logic src_match(input logic [4:0] src, input logic rd_en,
                                      input logic [4:0] dst, input logic wr);
      return rd_en && (src != 5'd0) && (src == dst) && wr;
   endfunction

   function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                          input logic [4:0] m_rd, input logic m_wr,
                                          input logic [4:0] w_rd, input logic w_wr);
      if (m_wr && (m_rd == src) && (src != 5'd0)) begin
         return 2'b01;
      end else if (w_wr && (w_rd == src) && (src != 5'd0)) begin
         return 2'b10;
      end else begin
         return 2'b00;
      end
   endfunction

`ifdef FORWARD_EN
   // With forwarding only a load directly ahead of its consumer needs a bubble.
   assign hazard_s = bus.ex_memread &
                     (src_match(bus.id_rs, bus.id_use_rs, bus.ex_rd, bus.ex_regwrite) |
                      src_match(bus.id_rt, bus.id_use_rt, bus.ex_rd, bus.ex_regwrite));
   assign fwd_a_s  = rst ? 2'b00 : fwd_sel(bus.ex_rs, bus.mem_rd, bus.mem_regwrite,
                                           bus.wb_rd, bus.wb_regwrite);
   assign fwd_b_s  = rst ? 2'b00 : fwd_sel(bus.ex_rt, bus.mem_rd, bus.mem_regwrite,
                                           bus.wb_rd, bus.wb_regwrite);
`else
   logic unused_ex_src_s;
   assign unused_ex_src_s = ^{bus.ex_rs, bus.ex_rt, bus.ex_memread};
   assign hazard_s = src_match(bus.id_rs, bus.id_use_rs, bus.ex_rd,  bus.ex_regwrite)  |
                     src_match(bus.id_rs, bus.id_use_rs, bus.mem_rd, bus.mem_regwrite) |
                     src_match(bus.id_rs, bus.id_use_rs, bus.wb_rd,  bus.wb_regwrite)  |
                     src_match(bus.id_rt, bus.id_use_rt, bus.ex_rd,  bus.ex_regwrite)  |
                     src_match(bus.id_rt, bus.id_use_rt, bus.mem_rd, bus.mem_regwrite) |
                     src_match(bus.id_rt, bus.id_use_rt, bus.wb_rd,  bus.wb_regwrite);
   assign fwd_a_s  = 2'b00;
   assign fwd_b_s  = 2'b00;
`endif

   // A branch seen while frozen is replayed on the first RUN cycle.
   assign branch_s = bus.branch_taken | br_pend_q;

   // Next-state and control-output decode.
   always_comb begin
      pc_en_s       = 1'b0;
      ifid_en_s     = 1'b0;
      idex_en_s     = 1'b0;
      exmem_en_s    = 1'b0;
      memwb_en_s    = 1'b0;
      ifid_flush_s  = 1'b0;
      idex_flush_s  = 1'b0;
      memwb_flush_s = 1'b0;
      state_d       = state_q;
      wait_d        = {WAIT_W{1'b0}};
      br_pend_d     = br_pend_q;
      if (rst) begin
         state_d = RUN;
      end else begin
         case (state_q)
            RUN: begin
               if (bus.dmem_req && !bus.dmem_ready) begin
                  memwb_en_s    = 1'b1;
                  memwb_flush_s = 1'b1;
                  state_d       = MEM_WAIT;
               end else begin
                  br_pend_d  = 1'b0;
                  idex_en_s  = 1'b1;
                  exmem_en_s = 1'b1;
                  memwb_en_s = 1'b1;
                  if (branch_s) begin
                     pc_en_s      = 1'b1;
                     ifid_en_s    = 1'b1;
                     ifid_flush_s = 1'b1;
                     idex_flush_s = 1'b1;
                  end else if (hazard_s) begin
                     idex_flush_s = 1'b1;
                  end else begin
                     pc_en_s   = 1'b1;
                     ifid_en_s = 1'b1;
                  end
               end
            end
            MEM_WAIT: begin
               if (bus.branch_taken) begin
                  br_pend_d = 1'b1;
               end else begin
                  br_pend_d = br_pend_q;
               end
               if (bus.dmem_ready) begin
                  pc_en_s    = 1'b1;
                  ifid_en_s  = 1'b1;
                  idex_en_s  = 1'b1;
                  exmem_en_s = 1'b1;
                  memwb_en_s = 1'b1;
                  state_d    = RUN;
               end else begin
                  memwb_en_s    = 1'b1;
                  memwb_flush_s = 1'b1;
                  if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                     state_d = ERR;
                  end else begin
                     wait_d = wait_q + WAIT_W'(1);
                  end
               end
            end
            ERR: begin
               memwb_flush_s = 1'b1;
            end
            default: begin
               state_d = RUN;
            end
         endcase
      end
   end

   // Stall counter saturates at all-ones.
   always_comb begin
      if (!pc_en_s && (stall_q != {CNT_W{1'b1}})) begin
         stall_d = stall_q + CNT_W'(1);
      end else begin
         stall_d = stall_q;
      end
   end

   // State and counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= RUN;
         wait_q    <= {WAIT_W{1'b0}};
         stall_q   <= {CNT_W{1'b0}};
         br_pend_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         stall_q   <= stall_d;
         br_pend_q <= br_pend_d;
      end
   end

   assign bus.pc_en       = pc_en_s;
   assign bus.ifid_en     = ifid_en_s;
   assign bus.idex_en     = idex_en_s;
   assign bus.exmem_en    = exmem_en_s;
   assign bus.memwb_en    = memwb_en_s;
   assign bus.ifid_flush  = ifid_flush_s;
   assign bus.idex_flush  = idex_flush_s;
   assign bus.memwb_flush = memwb_flush_s;
   assign bus.fwd_a       = fwd_a_s;
   assign bus.fwd_b       = fwd_b_s;
   assign bus.stall_cnt   = stall_q;
   assign bus.err         = (state_q == ERR);
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios then random traffic
// against a cycle-level reference model of the sequencing rules.
module tb_pipeline_hazard_ctrl;
   localparam int CW = 4;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pipeline_hazard_ctrl_if #(.CNT_W(CW)) bus ();
   pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

   int checks = 0;
   int errors = 0;

   // reference model state
   bit m_wait, m_err, m_pend;
   int m_waited, m_stalls;

   logic e_pc, e_ifid, e_idex, e_exmem, e_memwb, e_fi, e_fd, e_fm;
   logic [1:0] e_fa, e_fb;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit hazard_ref();
      logic [4:0] dst [3];
      bit         wr  [3];
      logic [4:0] src [2];
      bit         rdv [2];
      int n;
      dst = '{bus.ex_rd, bus.mem_rd, bus.wb_rd};
      wr  = '{bus.ex_regwrite, bus.mem_regwrite, bus.wb_regwrite};
      src = '{bus.id_rs, bus.id_rt};
      rdv = '{bus.id_use_rs, bus.id_use_rt};
`ifdef FORWARD_EN
      n = 1;
      if (!bus.ex_memread) return 1'b0;
`else
      n = 3;
`endif
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < n; j++)
            if (rdv[i] && src[i] != 5'd0 && src[i] == dst[j] && wr[j]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [1:0] fwd_ref(input logic [4:0] s);
      if (s == 5'd0) return 2'b00;
      if (bus.mem_regwrite && bus.mem_rd == s) return 2'b01;
      if (bus.wb_regwrite && bus.wb_rd == s) return 2'b10;
      return 2'b00;
   endfunction

   task automatic model_reset();
      m_wait = 1'b0; m_err = 1'b0; m_pend = 1'b0; m_waited = 0; m_stalls = 0;
   endtask

   task automatic all_en();
      e_pc = 1'b1; e_ifid = 1'b1; e_idex = 1'b1; e_exmem = 1'b1; e_memwb = 1'b1;
   endtask

   task automatic model_eval();
      bit freeze;
      {e_pc, e_ifid, e_idex, e_exmem, e_memwb, e_fi, e_fd, e_fm} = 8'h00;
      e_fa = 2'b00;
      e_fb = 2'b00;
      if (rst) return;
      freeze = 1'b0;
      if (m_err) e_fm = 1'b1;
      else if (m_wait) begin
         if (bus.dmem_ready) all_en(); else freeze = 1'b1;
      end
      else if (bus.dmem_req && !bus.dmem_ready) freeze = 1'b1;
      else if (bus.branch_taken || m_pend) begin all_en(); e_fi = 1'b1; e_fd = 1'b1; end
      else if (hazard_ref()) begin
         e_idex = 1'b1; e_exmem = 1'b1; e_memwb = 1'b1; e_fd = 1'b1;
      end
      else all_en();
      if (freeze) begin e_memwb = 1'b1; e_fm = 1'b1; end
`ifdef FORWARD_EN
      e_fa = fwd_ref(bus.ex_rs);
      e_fb = fwd_ref(bus.ex_rt);
`endif
   endtask

   task automatic model_next();
      if (rst) return;
      if (!e_pc && m_stalls < (1 << CW) - 1) m_stalls++;
      if (m_err) begin
      end else if (m_wait) begin
         if (bus.branch_taken) m_pend = 1'b1;
         if (bus.dmem_ready) m_wait = 1'b0;
         else if (m_waited == TO - 1) begin m_wait = 1'b0; m_err = 1'b1; end
         else m_waited++;
      end else if (bus.dmem_req && !bus.dmem_ready) begin
         m_wait = 1'b1; m_waited = 0;
      end else m_pend = 1'b0;
   endtask

   task automatic check_all();
      chk("pc_en", bus.pc_en, e_pc);
      chk("ifid_en", bus.ifid_en, e_ifid);
      chk("idex_en", bus.idex_en, e_idex);
      chk("exmem_en", bus.exmem_en, e_exmem);
      chk("memwb_en", bus.memwb_en, e_memwb);
      chk("ifid_flush", bus.ifid_flush, e_fi);
      chk("idex_flush", bus.idex_flush, e_fd);
      chk("memwb_flush", bus.memwb_flush, e_fm);
      chk("fwd_a", bus.fwd_a, e_fa);
      chk("fwd_b", bus.fwd_b, e_fb);
      chk("stall_cnt", bus.stall_cnt, m_stalls);
      chk("err", bus.err, m_err);
   endtask

   task automatic tick();
      #1;
      model_eval();
      check_all();
      model_next();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      bus.id_rs = 5'd0; bus.id_rt = 5'd0; bus.id_use_rs = 1'b0; bus.id_use_rt = 1'b0;
      bus.ex_rd = 5'd0; bus.ex_regwrite = 1'b0; bus.ex_memread = 1'b0;
      bus.mem_rd = 5'd0; bus.wb_rd = 5'd0; bus.mem_regwrite = 1'b0; bus.wb_regwrite = 1'b0;
      bus.ex_rs = 5'd0; bus.ex_rt = 5'd0; bus.branch_taken = 1'b0;
      bus.dmem_req = 1'b0; bus.dmem_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      tick();
      rst = 1'b0;
   endtask

   task automatic random_inputs();
      bus.id_rs = 5'($urandom_range(0, 3));
      bus.id_rt = 5'($urandom_range(0, 3));
      bus.id_use_rs = 1'($urandom_range(0, 1));
      bus.id_use_rt = 1'($urandom_range(0, 1));
      bus.ex_rd = 5'($urandom_range(0, 3));
      bus.mem_rd = 5'($urandom_range(0, 3));
      bus.wb_rd = 5'($urandom_range(0, 3));
      bus.ex_regwrite = 1'($urandom_range(0, 1));
      bus.mem_regwrite = 1'($urandom_range(0, 1));
      bus.wb_regwrite = 1'($urandom_range(0, 1));
      bus.ex_memread = 1'($urandom_range(0, 1));
      bus.ex_rs = 5'($urandom_range(0, 3));
      bus.ex_rt = 5'($urandom_range(0, 3));
      bus.branch_taken = ($urandom_range(0, 7) == 0);
      bus.dmem_req = ($urandom_range(0, 5) == 0);
      bus.dmem_ready = m_wait ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 1) == 0);
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      model_reset();
      @(negedge clk);
      do_reset();

      // RAW on $5 walking from EX through MEM to WB
      bus.id_rs = 5'd5; bus.id_use_rs = 1'b1;
      bus.ex_rd = 5'd5; bus.ex_regwrite = 1'b1;
      tick();
      bus.ex_rd = 5'd0; bus.ex_regwrite = 1'b0; bus.mem_rd = 5'd5; bus.mem_regwrite = 1'b1;
      tick();
      bus.mem_rd = 5'd0; bus.mem_regwrite = 1'b0; bus.wb_rd = 5'd5; bus.wb_regwrite = 1'b1;
      tick();
      clear_inputs();
      #1;
`ifndef FORWARD_EN
      chk("raw_stall_cnt", bus.stall_cnt, 32'd3);
`endif
      chk("raw_clear_pc_en", bus.pc_en, 32'd1);
      tick();

      // dmem busy for 4 cycles with branch held throughout
      bus.dmem_req = 1'b1; bus.branch_taken = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      bus.dmem_ready = 1'b1;
      tick();
      bus.dmem_req = 1'b0; bus.dmem_ready = 1'b0;
      #1;
      chk("resume_ifid_flush", bus.ifid_flush, 32'd1);
      chk("resume_idex_flush", bus.idex_flush, 32'd1);
`ifndef FORWARD_EN
      chk("wait_stall_cnt", bus.stall_cnt, 32'd7);
`endif
      tick();
      clear_inputs();

      // branch with simultaneous load-use hazard
      bus.branch_taken = 1'b1;
      bus.id_rs = 5'd8; bus.id_use_rs = 1'b1;
      bus.ex_rd = 5'd8; bus.ex_regwrite = 1'b1; bus.ex_memread = 1'b1;
      #1;
      chk("br_lu_pc_en", bus.pc_en, 32'd1);
      chk("br_lu_idex_flush", bus.idex_flush, 32'd1);
      tick();
      clear_inputs();

      // dmem never ready: timeout into sticky ERR, counter saturates
      bus.dmem_req = 1'b1;
      for (int i = 0; i < TO + 1 + 12; i++) tick();
      #1;
      chk("timeout_err", bus.err, 32'd1);
      chk("sat_stall_cnt", bus.stall_cnt, 32'd15);
      chk("err_memwb_en", bus.memwb_en, 32'd0);
      clear_inputs();
      do_reset();
      #1;
      chk("post_rst_err", bus.err, 32'd0);
      chk("post_rst_stall", bus.stall_cnt, 32'd0);
      tick();

      // random traffic with occasional resets
      for (int c = 0; c < 600; c++) begin
         if ((m_err && $urandom_range(0, 7) == 0) || $urandom_range(0, 99) == 0) begin
            random_inputs();
            do_reset();
         end else begin
            random_inputs();
            tick();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
